// File: rtl/rc5_decrypt_seq.sv
// rc5_decrypt_seq: iterative RC5-32/12/16 decryption core with an internal
// key schedule expanded from a 128-bit key.
// Optional build macro RC5_UNROLL2_EN: two decrypt rounds per cycle
// (ROUNDS must be even); otherwise one round per cycle.
module rc5_decrypt_seq #(
  parameter int          ROUNDS = 12,
  parameter logic [31:0] P32    = 32'hB7E15163,
  parameter logic [31:0] Q32    = 32'h9E3779B9
) (
  input  logic         clk,
  input  logic         clr,
  input  logic [127:0] key_in,
  input  logic         key_load,
  output logic         key_ready,
  input  logic [63:0]  din,
  input  logic         di_vld,
  output logic         di_rdy,
  output logic [63:0]  dout,
  output logic         do_vld
);
  localparam int T  = 2*ROUNDS + 2;
  localparam int IW = $clog2(T);
  localparam int RW = $clog2(ROUNDS + 1);
  localparam int CW = $clog2(3*T);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] KINIT  = 3'd1;
  localparam logic [2:0] KMIX   = 3'd2;
  localparam logic [2:0] DROUND = 3'd3;
  localparam logic [2:0] DFINAL = 3'd4;

  logic [2:0]    state_q, state_d;
  logic          key_ready_q, key_ready_d;
  logic          do_vld_q, do_vld_d;
  logic [63:0]   dout_q, dout_d;
  logic [31:0]   a_q, a_d, b_q, b_d;
  logic [IW-1:0] i_q, i_d;
  logic [1:0]    j_q, j_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] r_q, r_d;
  logic [31:0]   s_q [0:T-1];
  logic [31:0]   s_d [0:T-1];
  logic [31:0]   l_q [0:3];
  logic [31:0]   l_d [0:3];

  logic [31:0]   mix_a, mix_ab, mix_b;
  logic [IW-1:0] ie;
  logic [63:0]   rd1, rd2;

  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction

  function automatic logic [31:0] rotr32(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] t;
    t = {x, x} >> n;
    return t[31:0];
  endfunction

  // One inverse round: B is recovered first, then A using the new B.
  function automatic logic [63:0] dec_round(input logic [63:0] ab,
                                            input logic [31:0] s_even,
                                            input logic [31:0] s_odd);
    logic [31:0] a, b;
    a = ab[63:32];
    b = ab[31:0];
    b = rotr32(b - s_odd, a[4:0]) ^ a;
    a = rotr32(a - s_even, b[4:0]) ^ b;
    return {a, b};
  endfunction

  assign key_ready = key_ready_q;
  assign do_vld    = do_vld_q;
  assign dout      = dout_q;
  assign di_rdy    = (state_q == IDLE) & key_ready_q & ~key_load;

  // Next-state logic: key expansion, round datapath and handshake control.
  always_comb begin
    state_d     = state_q;
    key_ready_d = key_ready_q;
    do_vld_d    = 1'b0;
    dout_d      = dout_q;
    a_d         = a_q;
    b_d         = b_q;
    i_d         = i_q;
    j_d         = j_q;
    cnt_d       = cnt_q;
    r_d         = r_q;
    s_d         = s_q;
    l_d         = l_q;

    mix_a  = rotl32(s_q[i_q] + a_q + b_q, 5'd3);
    mix_ab = mix_a + b_q;
    mix_b  = rotl32(l_q[j_q] + mix_ab, mix_ab[4:0]);

    ie  = IW'(2*r_q);
    rd1 = dec_round({a_q, b_q}, s_q[ie], s_q[ie + 1'b1]);
`ifdef RC5_UNROLL2_EN
    rd2 = dec_round(rd1, s_q[ie - IW'(2)], s_q[ie - 1'b1]);
`else
    rd2 = rd1;
`endif

    case (state_q)
      IDLE: begin
        if (key_load) begin
          // Key load wins over a simultaneous block; the block waits.
          state_d     = KINIT;
          key_ready_d = 1'b0;
          for (int k = 0; k < 4; k++) l_d[k] = key_in[32*k +: 32];
          i_d = '0;
          a_d = P32;
        end else if (di_vld && key_ready_q) begin
          a_d     = din[63:32];
          b_d     = din[31:0];
          r_d     = RW'(ROUNDS);
          state_d = DROUND;
        end
      end
      KINIT: begin
        // a_q carries the running P + k*Q value.
        s_d[i_q] = a_q;
        a_d      = a_q + Q32;
        if (i_q == IW'(T-1)) begin
          i_d     = '0;
          j_d     = '0;
          cnt_d   = '0;
          a_d     = '0;
          b_d     = '0;
          state_d = KMIX;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      KMIX: begin
        s_d[i_q] = mix_a;
        l_d[j_q] = mix_b;
        a_d      = mix_a;
        b_d      = mix_b;
        i_d      = (i_q == IW'(T-1)) ? '0 : i_q + 1'b1;
        j_d      = j_q + 2'd1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(3*T-1)) begin
          state_d     = IDLE;
          key_ready_d = 1'b1;
        end
      end
      DROUND: begin
        a_d = rd2[63:32];
        b_d = rd2[31:0];
`ifdef RC5_UNROLL2_EN
        r_d = r_q - RW'(2);
        if (r_q == RW'(2)) state_d = DFINAL;
`else
        r_d = r_q - 1'b1;
        if (r_q == RW'(1)) state_d = DFINAL;
`endif
      end
      DFINAL: begin
        a_d      = a_q - s_q[0];
        b_d      = b_q - s_q[1];
        dout_d   = {a_d, b_d};
        do_vld_d = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and datapath registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= IDLE;
      key_ready_q <= 1'b0;
      do_vld_q    <= 1'b0;
      dout_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      cnt_q       <= '0;
      r_q         <= '0;
    end else begin
      state_q     <= state_d;
      key_ready_q <= key_ready_d;
      do_vld_q    <= do_vld_d;
      dout_q      <= dout_d;
      a_q         <= a_d;
      b_q         <= b_d;
      i_q         <= i_d;
      j_q         <= j_d;
      cnt_q       <= cnt_d;
      r_q         <= r_d;
    end
  end

  // Key schedule and key words; contents are meaningless until key_ready.
  always_ff @(posedge clk) begin
    s_q <= s_d;
    l_q <= l_d;
  end
endmodule

// File: tb/tb_rc5_decrypt_seq.sv
// Self-checking bench for rc5_decrypt_seq: directed vectors plus random
// round trips against an array-based RC5 reference model.
module tb_rc5_decrypt_seq;
`ifdef RC5_UNROLL2_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 13;
`endif

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic [127:0] key_in = '0;
  logic         key_load = 1'b0;
  logic         key_ready;
  logic [63:0]  din = '0;
  logic         di_vld = 1'b0;
  logic         di_rdy;
  logic [63:0]  dout;
  logic         do_vld;

  int n_tests = 0;
  int n_fail  = 0;

  rc5_decrypt_seq dut (
    .clk(clk), .clr(clr), .key_in(key_in), .key_load(key_load),
    .key_ready(key_ready), .din(din), .di_vld(di_vld), .di_rdy(di_rdy),
    .dout(dout), .do_vld(do_vld)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] ms [0:25];

  function automatic logic [31:0] rl(input logic [31:0] x, input logic [31:0] n);
    int k = int'(n & 32'd31);
    if (k == 0) return x;
    return (x << k) | (x >> (32 - k));
  endfunction

  function automatic logic [31:0] rr(input logic [31:0] x, input logic [31:0] n);
    int k = int'(n & 32'd31);
    if (k == 0) return x;
    return (x >> k) | (x << (32 - k));
  endfunction

  function automatic void model_key(input logic [127:0] k);
    logic [31:0] lw [0:3];
    logic [31:0] a, b;
    int i, j;
    for (int q = 0; q < 4; q++) lw[q] = k[32*q +: 32];
    ms[0] = 32'hB7E15163;
    for (int q = 1; q < 26; q++) ms[q] = ms[q-1] + 32'h9E3779B9;
    a = 0; b = 0; i = 0; j = 0;
    for (int n = 0; n < 78; n++) begin
      a = rl(ms[i] + a + b, 3);
      ms[i] = a;
      b = rl(lw[j] + a + b, a + b);
      lw[j] = b;
      i = (i + 1) % 26;
      j = (j + 1) % 4;
    end
  endfunction

  function automatic logic [63:0] model_enc(input logic [63:0] pt);
    logic [31:0] a, b;
    a = pt[63:32] + ms[0];
    b = pt[31:0] + ms[1];
    for (int r = 1; r <= 12; r++) begin
      a = rl(a ^ b, b) + ms[2*r];
      b = rl(b ^ a, a) + ms[2*r+1];
    end
    return {a, b};
  endfunction

  function automatic logic [63:0] model_dec(input logic [63:0] ct);
    logic [31:0] a, b;
    a = ct[63:32];
    b = ct[31:0];
    for (int r = 12; r >= 1; r--) begin
      b = rr(b - ms[2*r+1], a) ^ a;
      a = rr(a - ms[2*r], b) ^ b;
    end
    return {a - ms[0], b - ms[1]};
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k, output int cyc);
    key_in   = k;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    cyc = 0;
    while (cyc < 300) begin
      tick();
      cyc++;
      if (key_ready) break;
    end
    model_key(k);
  endtask

  // Waits for di_rdy, transfers one block, then waits for do_vld.
  // kl_mid pulses key_load during the decrypt, which must be ignored.
  task automatic send(input logic [63:0] ct, input bit kl_mid,
                      output int lat, output logic [63:0] res);
    int w = 0;
    while (!di_rdy && w < 300) begin
      tick();
      w++;
    end
    din    = ct;
    di_vld = 1'b1;
    tick();
    di_vld = 1'b0;
    din    = {$urandom(), $urandom()};
    lat = 0;
    while (lat < 300) begin
      key_load = kl_mid && (lat == 0);
      if (key_load) key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      tick();
      lat++;
      if (do_vld) break;
    end
    key_load = 1'b0;
    res = dout;
    tick();
    check("do_vld_pulse", {63'd0, do_vld}, 64'd0);
    check("dout_held", dout, res);
  endtask

  logic [63:0] pt, ct, res;
  int          cyc, lat, nv, tx;
  bit          acc_next;

  initial begin
    // 1. reset
    clr = 1'b1;
    tick();
    tick();
    check("rst_key_ready", {63'd0, key_ready}, 64'd0);
    check("rst_di_rdy", {63'd0, di_rdy}, 64'd0);
    check("rst_do_vld", {63'd0, do_vld}, 64'd0);
    check("rst_dout", dout, 64'd0);
    clr = 1'b0;

    // di_vld before any key is never accepted
    din = 64'h0123456789abcdef;
    di_vld = 1'b1;
    nv = 0;
    repeat (20) begin
      tick();
      if (do_vld || di_rdy) nv++;
    end
    di_vld = 1'b0;
    check("no_key_no_accept", 64'(nv), 64'd0);

    // 2. key expansion timing
    load_key(128'h1, cyc);
    check("key_ready_104", 64'(cyc), 64'd104);

    // 3. known vector under key 1 (model) and the standard zero-key vector
    send(64'heedba5216d8f4b15, 1'b0, lat, res);
    check("vec_k1_lat", 64'(lat), 64'(LAT));
    check("vec_k1_dout", res, model_dec(64'heedba5216d8f4b15));
    load_key(128'h0, cyc);
    check("key0_ready_104", 64'(cyc), 64'd104);
    send(64'heedba5216d8f4b15, 1'b0, lat, res);
    check("vec_k0_lat", 64'(lat), 64'(LAT));
    check("vec_k0_dout", res, 64'h0);

    // 4. random round trips; one block also sees an ignored key_load
    load_key({$urandom(), $urandom(), $urandom(), $urandom()}, cyc);
    check("rkey_ready_104", 64'(cyc), 64'd104);
    for (int n = 0; n < 20; n++) begin
      pt = {$urandom(), $urandom()};
      ct = model_enc(pt);
      send(ct, n == 5, lat, res);
      check("rt_lat", 64'(lat), 64'(LAT));
      check("rt_dout", res, pt);
      if (n == 5) check("kl_busy_ignored", {63'd0, key_ready}, 64'd1);
    end

    // 5. key_load and di_vld together in IDLE
    key_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    model_key(key_in);
    pt = {$urandom(), $urandom()};
    ct = model_enc(pt);
    din = ct;
    di_vld = 1'b1;
    key_load = 1'b1;
    tick();
    key_load = 1'b0;
    check("kl_prio_ready", {63'd0, key_ready}, 64'd0);
    nv = 0;
    tx = -1;
    while (nv < 400) begin
      acc_next = di_rdy && di_vld;
      tick();
      nv++;
      if (acc_next) begin
        di_vld = 1'b0;
        tx = nv;
      end
      if (do_vld) break;
    end
    di_vld = 1'b0;
    check("kl_prio_tx", 64'(tx), 64'd105);
    check("kl_prio_lat", 64'(nv), 64'(105 + LAT));
    check("kl_prio_dout", dout, pt);

    // 6. clr mid-decrypt aborts the block and invalidates the key
    din = {$urandom(), $urandom()};
    di_vld = 1'b1;
    tick();
    di_vld = 1'b0;
    nv = 0;
    repeat (4) begin
      tick();
      if (do_vld) nv++;
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    di_vld = 1'b1;
    repeat (20) begin
      tick();
      if (do_vld) nv++;
    end
    di_vld = 1'b0;
    check("abort_no_vld", 64'(nv), 64'd0);
    check("abort_key_ready", {63'd0, key_ready}, 64'd0);
    check("abort_di_rdy", {63'd0, di_rdy}, 64'd0);
    load_key(128'h0, cyc);
    check("reload_ready_104", 64'(cyc), 64'd104);
    send(64'heedba5216d8f4b15, 1'b0, lat, res);
    check("reload_lat", 64'(lat), 64'(LAT));
    check("reload_dout", res, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
